// File: rtl/ysyx_22050612_ifu_pkg.sv
// ============================================================================
// Module      : ysyx_22050612_ifu_pkg
// Description : Shared constants, FSM state encoding and helpers for the IFU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_22050612_ifu_pkg;

    localparam int          XLEN         = 64;
    localparam int          ILEN         = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } ifu_state_e;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050612_ifu_if.sv
// ============================================================================
// Module      : ysyx_22050612_ifu_if
// Description : IFU bundle: imem request/response channel plus downstream
//               instruction handshake. master = IFU side, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_22050612_ifu_if
    import ysyx_22050612_ifu_pkg::*;
#(
    parameter int IF_XLEN = XLEN,
    parameter int IF_ILEN = ILEN
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [IF_XLEN-1:0] imem_req_addr;
    logic               imem_rsp_valid;
    logic [IF_ILEN-1:0] imem_rsp_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [IF_ILEN-1:0] inst;
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] dnpc;
    logic               fetch_err;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, dnpc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, dnpc
    );

endinterface

`default_nettype wire

// File: rtl/ysyx_22050612_pc_reg.sv
// ============================================================================
// Module      : ysyx_22050612_pc_reg
// Description : XLEN-wide PC register, async active-low reset to RESET_PC,
//               loaded from d_i when load_i is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050612_pc_reg #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            load_i,
    input  wire logic [XLEN-1:0] d_i,
    output logic      [XLEN-1:0] q_o
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050612_ifu.sv
// ============================================================================
// Module      : ysyx_22050612_ifu
// Description : Single-outstanding instruction fetch unit. Optional alignment
//               check enabled by macro YSYX_22050612_IFU_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050612_ifu
    import ysyx_22050612_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    ysyx_22050612_ifu_if.master bus
);

    ifu_state_e      state_q;
    logic            req_valid_q;
    logic            inst_valid_q;
    logic [ILEN-1:0] inst_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pc_load;

    // The PC only ever changes at the downstream handshake; dnpc is taken verbatim.
    assign pc_load = (state_q == ST_HOLD) && bus.inst_ready;
    assign pc_d    = bus.dnpc;

    ysyx_22050612_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

`ifdef YSYX_22050612_IFU_ALIGN_CHECK_EN
    logic fetch_err_q;
    logic dnpc_bad;
    logic reset_pc_bad;

    assign dnpc_bad     = misaligned(bus.dnpc[1:0]);
    assign reset_pc_bad = misaligned(RESET_PC[1:0]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
`ifdef YSYX_22050612_IFU_ALIGN_CHECK_EN
            fetch_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef YSYX_22050612_IFU_ALIGN_CHECK_EN
                    if (reset_pc_bad) begin
                        state_q     <= ST_HALT;
                        fetch_err_q <= 1'b1;
                    end else begin
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
                    end
`else
                    state_q     <= ST_REQ;
                    req_valid_q <= 1'b1;
`endif
                end
                ST_REQ: begin
                    if (bus.imem_req_ready) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        inst_q       <= bus.imem_rsp_data;
                        state_q      <= ST_HOLD;
                        inst_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.inst_ready) begin
                        inst_valid_q <= 1'b0;
`ifdef YSYX_22050612_IFU_ALIGN_CHECK_EN
                        if (dnpc_bad) begin
                            state_q     <= ST_HALT;
                            fetch_err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                        end
`else
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef YSYX_22050612_IFU_ALIGN_CHECK_EN
                // Terminal until reset.
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
`endif
                default: begin
                    state_q      <= ST_IDLE;
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.pc             = pc_q;
`ifdef YSYX_22050612_IFU_ALIGN_CHECK_EN
    assign bus.fetch_err      = fetch_err_q;
`else
    assign bus.fetch_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050612_ifu.sv
// ============================================================================
// Module      : tb_ysyx_22050612_ifu
// Description : Scoreboard bench for ysyx_22050612_ifu (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22050612_ifu;
    import ysyx_22050612_ifu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050612_ifu_if ifc ();

    ysyx_22050612_ifu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] exp_req  [$];
    logic [95:0] exp_inst [$];
    logic [63:0] mon_req;
    logic [95:0] mon_inst;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event within 50 cycles", name);
    endtask

    // Monitor: pops expectations whenever a handshake is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.imem_req_valid && ifc.imem_req_ready) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_extra: actual addr=%h required=no request", ifc.imem_req_addr);
                end else begin
                    mon_req = exp_req.pop_front();
                    chk("req_addr", ifc.imem_req_addr, mon_req);
                end
            end
            if (ifc.inst_valid && ifc.inst_ready) begin
                if (exp_inst.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL inst_extra: actual inst=%h required=no instruction", ifc.inst);
                end else begin
                    mon_inst = exp_inst.pop_front();
                    chk("inst_data", {32'h0, ifc.inst}, {32'h0, mon_inst[31:0]});
                    chk("inst_pc", ifc.pc, mon_inst[95:32]);
                end
            end
        end
    end

    task automatic fetch(input logic [63:0] addr, input logic [31:0] data,
                         input int req_lat, input int mem_lat, input int hold_lat,
                         input logic [63:0] nxt, input bit spurious, output int acc_cyc);
        int n;
        exp_req.push_back(addr);
        exp_inst.push_back({addr, data});
        n = 0;
        while (!ifc.imem_req_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) tmo("wait_req_valid");
        for (int i = 0; i < req_lat; i++) begin
            if (spurious && i == 0) begin
                ifc.imem_rsp_valid = 1'b1;
                ifc.imem_rsp_data  = 32'hDEAD_DEAD;
            end
            @(posedge clk); #1;
            ifc.imem_rsp_valid = 1'b0;
            chk("bp_req_valid", {63'h0, ifc.imem_req_valid}, 64'h1);
            chk("bp_req_addr", ifc.imem_req_addr, addr);
        end
        ifc.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        ifc.imem_req_ready = 1'b0;
        acc_cyc = cyc;
        for (int i = 1; i < mem_lat; i++) begin
            @(posedge clk); #1;
            chk("wait_quiet", {62'h0, ifc.imem_req_valid, ifc.inst_valid}, 64'h0);
        end
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = data;
        @(posedge clk); #1;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = 32'h5A5A_5A5A;
        n = 0;
        while (!ifc.inst_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) tmo("wait_inst_valid");
        for (int i = 0; i < hold_lat; i++) begin
            @(posedge clk); #1;
            chk("hold_inst", {32'h0, ifc.inst}, {32'h0, data});
            chk("hold_pc", ifc.pc, addr);
            chk("hold_no_req", {63'h0, ifc.imem_req_valid}, 64'h0);
        end
        ifc.inst_ready = 1'b1;
        ifc.dnpc       = nxt;
        @(posedge clk); #1;
        ifc.inst_ready = 1'b0;
        ifc.dnpc       = 64'hFFFF_FFFF_FFFF_FFF0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=no finish required=finish");
        $fatal(1);
    end

    initial begin
        int t1, t2, t_dummy, n;
        logic bad;
        ifc.imem_req_ready = 1'b0;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = '0;
        ifc.inst_ready     = 1'b0;
        ifc.dnpc           = 64'hFFFF_FFFF_FFFF_FFF0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", ifc.pc, 64'h8000_0000);
        chk("rst_inst", {32'h0, ifc.inst}, 64'h0);
        chk("rst_valids", {61'h0, ifc.imem_req_valid, ifc.inst_valid, ifc.fetch_err}, 64'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_no_req", {63'h0, ifc.imem_req_valid}, 64'h0);
        @(posedge clk); #1;
        chk("first_req_valid", {63'h0, ifc.imem_req_valid}, 64'h1);
        chk("first_req_addr", ifc.imem_req_addr, 64'h8000_0000);

        fetch(64'h8000_0000, 32'h0000_0413, 0, 1, 0, 64'h8000_0004, 0, t1);
        fetch(64'h8000_0004, 32'h0010_0093, 0, 1, 0, 64'h8000_0008, 0, t2);
        chk("loop_cycles", 64'(t2 - t1), 64'd3);
        fetch(64'h8000_0008, 32'h0020_8113, 5, 1, 4, 64'h8000_000C, 0, t_dummy);
        fetch(64'h8000_000C, 32'h0031_0193, 2, 7, 0, 64'h8000_0100, 1, t_dummy);
        fetch(64'h8000_0100, 32'h1234_5678, 0, 2, 1, 64'h0, 0, t_dummy);
        fetch(64'h0,         32'hCAFE_BABE, 0, 1, 0, 64'h8000_0040, 0, t_dummy);

        // Reset while waiting on memory; stale responses must never surface.
        exp_req.push_back(64'h8000_0040);
        n = 0;
        while (!ifc.imem_req_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) tmo("wait_req_valid_rst");
        ifc.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        ifc.imem_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", ifc.pc, 64'h8000_0000);
        chk("arst_inst", {32'h0, ifc.inst}, 64'h0);
        chk("arst_valids", {62'h0, ifc.imem_req_valid, ifc.inst_valid}, 64'h0);
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'hBAAD_BAAD;
        @(posedge clk); #1;
        ifc.imem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'hBAAD_F00D;
        @(posedge clk); #1;
        ifc.imem_rsp_valid = 1'b0;
        chk("post_rst_inst", {32'h0, ifc.inst}, 64'h0);
        chk("post_rst_req", {62'h0, ifc.imem_req_valid, ifc.inst_valid}, 64'h2);
        chk("post_rst_addr", ifc.imem_req_addr, 64'h8000_0000);
        fetch(64'h8000_0000, 32'h0000_0513, 0, 3, 0, 64'h8000_0002, 0, t_dummy);

`ifdef YSYX_22050612_IFU_ALIGN_CHECK_EN
        chk("align_err", {63'h0, ifc.fetch_err}, 64'h1);
        chk("align_pc", ifc.pc, 64'h8000_0002);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ifc.imem_req_valid || ifc.inst_valid) bad = 1'b1;
        end
        chk("halt_quiet", {63'h0, bad}, 64'h0);
        chk("err_sticky", {63'h0, ifc.fetch_err}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_err", {63'h0, ifc.fetch_err}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("halt_exit_req", {63'h0, ifc.imem_req_valid}, 64'h1);
`else
        chk("noalign_err", {63'h0, ifc.fetch_err}, 64'h0);
        fetch(64'h8000_0002, 32'h0000_0093, 0, 1, 0, 64'h8000_0006, 0, t_dummy);
        chk("noalign_err_after", {63'h0, ifc.fetch_err}, 64'h0);
        chk("noalign_next_pc", ifc.pc, 64'h8000_0006);
`endif

        @(posedge clk); #1;
        chk("req_q_empty", 64'(exp_req.size()), 64'h0);
        chk("inst_q_empty", 64'(exp_inst.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
